// File: rtl/ascensor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ascensor_pkg: state encoding, action codes, button codes, code-to-floor map
// Rev 1.0
// ---------------------------------------------------------------------------
package ascensor_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUBE = 2'd1;
  localparam logic [1:0] BAJA = 2'd2;

  localparam int N_CODIGOS = 10;

  localparam logic [3:0] BTN_NINGUNO = 4'd0;
  localparam logic [3:0] BTN_CAB_P1  = 4'd1;
  localparam logic [3:0] BTN_CAB_P2  = 4'd2;
  localparam logic [3:0] BTN_CAB_P3  = 4'd3;
  localparam logic [3:0] BTN_CAB_P4  = 4'd4;
  localparam logic [3:0] BTN_P1_SUBE = 4'd5;
  localparam logic [3:0] BTN_P2_BAJA = 4'd6;
  localparam logic [3:0] BTN_P2_SUBE = 4'd7;
  localparam logic [3:0] BTN_P3_BAJA = 4'd8;
  localparam logic [3:0] BTN_P3_SUBE = 4'd9;
  localparam logic [3:0] BTN_P4_BAJA = 4'd10;

  function automatic logic codigo_valido(input logic [3:0] codigo);
    codigo_valido = (codigo != BTN_NINGUNO) && (codigo <= BTN_P4_BAJA);
  endfunction

  // Only meaningful for valid codes; callers gate with codigo_valido.
  function automatic logic [1:0] piso_de_codigo(input logic [3:0] codigo);
    case (codigo)
      BTN_CAB_P1, BTN_P1_SUBE:              piso_de_codigo = 2'd0;
      BTN_CAB_P2, BTN_P2_BAJA, BTN_P2_SUBE: piso_de_codigo = 2'd1;
      BTN_CAB_P3, BTN_P3_BAJA, BTN_P3_SUBE: piso_de_codigo = 2'd2;
      default:                              piso_de_codigo = 2'd3;
    endcase
  endfunction

  function automatic logic [N_CODIGOS-1:0] mascara_piso(input logic [1:0] piso);
    logic [N_CODIGOS-1:0] m;
    m = '0;
    for (int c = 1; c <= N_CODIGOS; c++) begin
      if (piso_de_codigo(4'(c)) == piso) m[c-1] = 1'b1;
    end
    mascara_piso = m;
  endfunction

  function automatic logic [N_CODIGOS-1:0] mascara_cabina(input logic [1:0] piso);
    mascara_cabina = N_CODIGOS'(1) << piso;
  endfunction

  function automatic logic [N_CODIGOS-1:0] mascara_sube(input logic [1:0] piso);
    case (piso)
      2'd0:    mascara_sube = N_CODIGOS'(1) << (BTN_P1_SUBE - 4'd1);
      2'd1:    mascara_sube = N_CODIGOS'(1) << (BTN_P2_SUBE - 4'd1);
      2'd2:    mascara_sube = N_CODIGOS'(1) << (BTN_P3_SUBE - 4'd1);
      default: mascara_sube = '0;
    endcase
  endfunction

  function automatic logic [N_CODIGOS-1:0] mascara_baja(input logic [1:0] piso);
    case (piso)
      2'd1:    mascara_baja = N_CODIGOS'(1) << (BTN_P2_BAJA - 4'd1);
      2'd2:    mascara_baja = N_CODIGOS'(1) << (BTN_P3_BAJA - 4'd1);
      2'd3:    mascara_baja = N_CODIGOS'(1) << (BTN_P4_BAJA - 4'd1);
      default: mascara_baja = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/selector_objetivo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// selector_objetivo: nearest pending floor above/below the cabin, and
// whether anything is pending further in the given direction. Rev 1.0
// ---------------------------------------------------------------------------
module selector_objetivo
  import ascensor_pkg::*;
(
  input  logic [N_CODIGOS-1:0] pendientes,
  input  logic [1:0]           piso,
  input  logic [1:0]           direccion,
  output logic                 hay_arriba,
  output logic [1:0]           obj_arriba,
  output logic                 hay_abajo,
  output logic [1:0]           obj_abajo,
  output logic                 mas_en_dir
);

  logic [3:0] ocupado;

  always_comb begin
    for (int f = 0; f < 4; f++) begin
      ocupado[f] = |(pendientes & mascara_piso(2'(f)));
    end

    // Scanning from the far end lets the closest floor overwrite the result.
    hay_arriba = 1'b0;
    obj_arriba = piso;
    for (int f = 3; f >= 0; f--) begin
      if ((f > int'(piso)) && ocupado[f]) begin
        hay_arriba = 1'b1;
        obj_arriba = 2'(f);
      end
    end

    hay_abajo = 1'b0;
    obj_abajo = piso;
    for (int f = 0; f < 4; f++) begin
      if ((f < int'(piso)) && ocupado[f]) begin
        hay_abajo = 1'b1;
        obj_abajo = 2'(f);
      end
    end

    mas_en_dir = (direccion == SUBE) ? hay_arriba :
                 (direccion == BAJA) ? hay_abajo  : 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/planificador_solicitudes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// planificador_solicitudes: four-floor elevator request scheduler.
// Optional macro PRIORIDAD_CABINA_EN: car calls dominate idle direction choice.
// Rev 1.0
// ---------------------------------------------------------------------------
module planificador_solicitudes
  import ascensor_pkg::*;
#(
  parameter int T_PUERTA  = 100000000,
  parameter int ANCHO_CNT = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0]           boton_pres,
  input  logic [1:0]           piso,
  input  logic                 llegada,
  output logic [1:0]           objetivo,
  output logic [1:0]           accion,
  output logic                 puertas,
  output logic [N_CODIGOS-1:0] pendientes
);

  localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(T_PUERTA - 1);

  estado_t              estado;
  logic [1:0]           dir;
  logic [ANCHO_CNT-1:0] cnt;

  logic                 boton_valido;
  logic                 nuevo_en_piso;
  logic                 hay_en_piso;
  logic                 parada;
  logic                 sube_gana;
  logic [1:0]           dist_arriba;
  logic [1:0]           dist_abajo;
  logic [N_CODIGOS-1:0] vec_set;
  logic [N_CODIGOS-1:0] vec_clr;
  logic [N_CODIGOS-1:0] mask_dir;
  logic [N_CODIGOS-1:0] pend_reposo;
  logic [N_CODIGOS-1:0] vec_selector;

  logic                 hay_arriba;
  logic [1:0]           obj_arriba;
  logic                 hay_abajo;
  logic [1:0]           obj_abajo;
  logic                 mas_en_dir;

`ifdef PRIORIDAD_CABINA_EN
  assign pend_reposo = (|pendientes[3:0]) ? {6'b0, pendientes[3:0]} : pendientes;
`else
  assign pend_reposo = pendientes;
`endif

  // Idle direction choice may use a filtered view; everything else sees all calls.
  assign vec_selector = (estado == REPOSO) ? pend_reposo : pendientes;

  selector_objetivo u_selector (
    .pendientes (vec_selector),
    .piso       (piso),
    .direccion  (dir),
    .hay_arriba (hay_arriba),
    .obj_arriba (obj_arriba),
    .hay_abajo  (hay_abajo),
    .obj_abajo  (obj_abajo),
    .mas_en_dir (mas_en_dir)
  );

  always_comb begin
    boton_valido  = codigo_valido(boton_pres);
    vec_set       = boton_valido ? (N_CODIGOS'(1) << (boton_pres - 4'd1)) : '0;
    nuevo_en_piso = boton_valido && (piso_de_codigo(boton_pres) == piso);
    hay_en_piso   = |(pendientes & mascara_piso(piso));
    mask_dir      = (dir == SUBE) ? mascara_sube(piso) : mascara_baja(piso);
    parada        = llegada &&
                    ((|(pendientes & (mascara_cabina(piso) | mask_dir))) || !mas_en_dir);
    dist_arriba   = obj_arriba - piso;
    dist_abajo    = piso - obj_abajo;
    sube_gana     = hay_arriba && (!hay_abajo || (dist_arriba <= dist_abajo));

    vec_clr = '0;
    case (estado)
      REPOSO:            if (hay_en_piso) vec_clr = mascara_piso(piso);
      SUBIENDO, BAJANDO: if (parada)
                           vec_clr = mascara_cabina(piso) | mask_dir |
                                     (mas_en_dir ? '0 : mascara_piso(piso));
      PUERTA:            if (nuevo_en_piso) vec_clr = vec_set;
      default:           vec_clr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado     <= REPOSO;
      dir        <= IDLE;
      cnt        <= '0;
      objetivo   <= 2'd0;
      accion     <= IDLE;
      puertas    <= 1'b0;
      pendientes <= '0;
    end else if (en) begin
      // Clear is applied after set so a simultaneous clear wins.
      pendientes <= (pendientes | vec_set) & ~vec_clr;
      case (estado)
        REPOSO: begin
          if (hay_en_piso) begin
            estado   <= PUERTA;
            dir      <= IDLE;
            cnt      <= '0;
            puertas  <= 1'b1;
            accion   <= IDLE;
            objetivo <= piso;
          end else if (sube_gana) begin
            estado   <= SUBIENDO;
            dir      <= SUBE;
            accion   <= SUBE;
            objetivo <= obj_arriba;
          end else if (hay_abajo) begin
            estado   <= BAJANDO;
            dir      <= BAJA;
            accion   <= BAJA;
            objetivo <= obj_abajo;
          end
        end

        SUBIENDO, BAJANDO: begin
          if (parada) begin
            estado   <= PUERTA;
            cnt      <= '0;
            puertas  <= 1'b1;
            accion   <= IDLE;
            objetivo <= piso;
          end else if ((estado == SUBIENDO) && hay_arriba) begin
            objetivo <= obj_arriba;
          end else if ((estado == BAJANDO) && hay_abajo) begin
            objetivo <= obj_abajo;
          end
        end

        PUERTA: begin
          if (nuevo_en_piso) begin
            cnt <= '0;
          end else if (cnt == CNT_FIN) begin
            cnt     <= '0;
            puertas <= 1'b0;
            // Keep going the same way if possible, otherwise reverse.
            if (((dir == SUBE) && hay_arriba) || ((dir == BAJA) && !hay_abajo && hay_arriba)) begin
              estado   <= SUBIENDO;
              dir      <= SUBE;
              accion   <= SUBE;
              objetivo <= obj_arriba;
            end else if ((dir != IDLE) && hay_abajo) begin
              estado   <= BAJANDO;
              dir      <= BAJA;
              accion   <= BAJA;
              objetivo <= obj_abajo;
            end else begin
              estado <= REPOSO;
              dir    <= IDLE;
              accion <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
`default_nettype wire
